// File: rtl/sqrt_arb.sv
// Two-port round-robin front end for a shared sqrt core.
// One transaction in flight; timeout aborts a silent core.
module sqrt_arb #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] a0,
  output logic        ack0,
  output logic [15:0] res0,
  input  logic        req1,
  input  logic [15:0] a1,
  output logic        ack1,
  output logic [15:0] res1,
  output logic        err,
  output logic        busy,
  output logic        core_init,
  output logic [15:0] core_a,
  input  logic [15:0] core_result,
  input  logic        core_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic       gnt_q;
  logic       last_q;
  logic [7:0] cnt_q;
  logic       pick;
  logic       req_gnt;
  logic       any_req;

  assign any_req = req0 | req1;
  assign pick    = (req0 & req1) ? ~last_q : req1;
  assign req_gnt = gnt_q ? req1 : req0;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (core_done || cnt_q == TO_LAST)
                 state_d = S_RESP;
      S_RESP:  if (!req_gnt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // state-derived outputs
  always_comb begin
    core_init = (state_q == S_START);
    busy      = (state_q != S_IDLE);
    ack0      = (state_q == S_RESP) & ~gnt_q;
    ack1      = (state_q == S_RESP) &  gnt_q;
  end

  // grant capture, timeout counter and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q  <= 1'b0;
      last_q <= 1'b1;
      cnt_q  <= '0;
      core_a <= '0;
      res0   <= '0;
      res1   <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            gnt_q  <= pick;
            last_q <= pick;
            core_a <= pick ? a1 : a0;
          end
        end
        S_START: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (core_done) begin
            if (gnt_q) res1 <= core_result;
            else       res0 <= core_result;
            err <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            if (gnt_q) res1 <= 16'hFFFF;
            else       res0 <= 16'hFFFF;
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_arb.sv
// Directed bench for sqrt_arb.
// Core responses are driven by hand.
module tb_sqrt_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] a0 = '0;
  logic [15:0] a1 = '0;
  logic        ack0, ack1, err, busy, core_init;
  logic [15:0] res0, res1, core_a;
  logic [15:0] core_result = '0;
  logic        core_done = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  sqrt_arb #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .ack0(ack0), .res0(res0),
    .req1(req1), .a1(a1), .ack1(ack1), .res1(res1),
    .err(err), .busy(busy),
    .core_init(core_init), .core_a(core_a),
    .core_result(core_result), .core_done(core_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && ack0 && ack1) begin
      n_err++;
      $display("FAIL ack_overlap: ack0=%0b ack1=%0b want not both", ack0, ack1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE with reqs already driven;
  // returns which ack rose (0/1, 2 none, 3 both).
  task automatic serve(input logic [15:0] r, output int g);
    tick();
    tick();
    core_done = 1'b1;
    core_result = r;
    tick();
    g = ack1 ? (ack0 ? 3 : 1) : (ack0 ? 0 : 2);
    core_done = 1'b0;
    if (g == 0) req0 = 1'b0;
    else if (g == 1) req1 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL rst_ack0: got %0b want 0", ack0); end
    n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL rst_ack1: got %0b want 0", ack1); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b want 0", busy); end
    n_cmp++; if (core_init !== 1'b0) begin n_err++; $display("FAIL rst_init: got %0b want 0", core_init); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0b want 0", err); end
    n_cmp++; if (core_a !== 16'h0) begin n_err++; $display("FAIL rst_core_a: got %0h want 0", core_a); end
    n_cmp++; if (res0 !== 16'h0) begin n_err++; $display("FAIL rst_res0: got %0h want 0", res0); end
    n_cmp++; if (res1 !== 16'h0) begin n_err++; $display("FAIL rst_res1: got %0h want 0", res1); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_simul();
    req0 = 1'b1; a0 = 16'hFFFF;
    req1 = 1'b1; a1 = 16'd4;
    tick();
    n_cmp++; if (core_a !== 16'hFFFF) begin n_err++; $display("FAIL simul_core_a0: got %0h want ffff", core_a); end
    tick();
    core_done = 1'b1; core_result = 16'd255;
    tick();
    n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL simul_ack0: got %0b want 1", ack0); end
    n_cmp++; if (ack1 !== 1'b0) begin n_err++; $display("FAIL simul_ack1_low: got %0b want 0", ack1); end
    n_cmp++; if (res0 !== 16'd255) begin n_err++; $display("FAIL simul_res0: got %0d want 255", res0); end
    core_done = 1'b0; req0 = 1'b0;
    tick();
    tick();
    n_cmp++; if (core_a !== 16'd4) begin n_err++; $display("FAIL simul_core_a1: got %0h want 4", core_a); end
    tick();
    core_done = 1'b1; core_result = 16'd2;
    tick();
    n_cmp++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL simul_ack1: got %0b want 1", ack1); end
    n_cmp++; if (res1 !== 16'd2) begin n_err++; $display("FAIL simul_res1: got %0d want 2", res1); end
    core_done = 1'b0; req1 = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int g;
    for (int p = 0; p < 3; p++) begin
      req0 = 1'b1; a0 = 16'(p + 1);
      req1 = 1'b1; a1 = 16'(p + 10);
      for (int k = 0; k < 2; k++) begin
        serve(16'(p * 2 + k), g);
        n_cmp++;
        if (g !== k) begin
          n_err++;
          $display("FAIL b2b_order[%0d]: got %0d want %0d", p * 2 + k, g, k);
        end
      end
    end
  endtask

  task automatic test_basic();
    req0 = 1'b1; a0 = 16'd144;
    tick();
    n_cmp++; if (core_init !== 1'b1) begin n_err++; $display("FAIL basic_init: got %0b want 1", core_init); end
    n_cmp++; if (core_a !== 16'd144) begin n_err++; $display("FAIL basic_core_a: got %0d want 144", core_a); end
    tick();
    n_cmp++; if (core_init !== 1'b0) begin n_err++; $display("FAIL basic_init_pulse: got %0b want 0", core_init); end
    repeat (16) tick();
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL basic_ack_early: got %0b want 0", ack0); end
    core_done = 1'b1; core_result = 16'd12;
    tick();
    n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL basic_ack: got %0b want 1", ack0); end
    n_cmp++; if (res0 !== 16'd12) begin n_err++; $display("FAIL basic_res0: got %0d want 12", res0); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %0b want 0", err); end
    core_done = 1'b0; req0 = 1'b0;
    tick();
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL basic_ack_drop: got %0b want 0", ack0); end
  endtask

  task automatic test_single_rr();
    int g;
    req0 = 1'b1; a0 = 16'd9;
    serve(16'd3, g);
    n_cmp++; if (g !== 0) begin n_err++; $display("FAIL single_gnt: got %0d want 0", g); end
    req0 = 1'b1; req1 = 1'b1; a1 = 16'd81;
    serve(16'd9, g);
    n_cmp++; if (g !== 1) begin n_err++; $display("FAIL rr_first: got %0d want 1", g); end
    serve(16'd3, g);
    n_cmp++; if (g !== 0) begin n_err++; $display("FAIL rr_second: got %0d want 0", g); end
  endtask

  task automatic test_drop();
    req0 = 1'b1; a0 = 16'd36;
    tick();
    req0 = 1'b0;
    tick();
    core_done = 1'b1; core_result = 16'd6;
    tick();
    n_cmp++; if (ack0 !== 1'b1) begin n_err++; $display("FAIL drop_ack: got %0b want 1", ack0); end
    n_cmp++; if (res0 !== 16'd6) begin n_err++; $display("FAIL drop_res0: got %0d want 6", res0); end
    core_done = 1'b0;
    tick();
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL drop_pulse: got %0b want 0", ack0); end
  endtask

  task automatic test_hold();
    req1 = 1'b1; a1 = 16'd16;
    tick();
    tick();
    core_done = 1'b1; core_result = 16'd4;
    tick();
    n_cmp++; if (ack1 !== 1'b1) begin n_err++; $display("FAIL hold_ack: got %0b want 1", ack1); end
    n_cmp++; if (res1 !== 16'd4) begin n_err++; $display("FAIL hold_res1: got %0d want 4", res1); end
    core_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (ack1 !== 1'b1 || core_init !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cyc%0d: ack1=%0b init=%0b want 1/0", i, ack1, core_init);
      end
    end
    req1 = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_idle: busy=%0b want 0", busy); end
  endtask

  task automatic test_timeout();
    int k;
    int g;
    req1 = 1'b1; a1 = 16'd7;
    tick();
    tick();
    k = 0;
    while (!ack1 && k < 200) begin
      tick();
      k++;
    end
    n_cmp++; if (k !== 64) begin n_err++; $display("FAIL to_cycles: got %0d want 64", k); end
    n_cmp++; if (res1 !== 16'hFFFF) begin n_err++; $display("FAIL to_res1: got %0h want ffff", res1); end
    n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL to_err: got %0b want 1", err); end
    req1 = 1'b0;
    tick();
    req0 = 1'b1; a0 = 16'd25;
    serve(16'd5, g);
    n_cmp++; if (g !== 0) begin n_err++; $display("FAIL to_next_gnt: got %0d want 0", g); end
    n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL to_err_clr: got %0b want 0", err); end
    n_cmp++; if (res0 !== 16'd5) begin n_err++; $display("FAIL to_next_res0: got %0d want 5", res0); end
  endtask

  task automatic test_reset_mid();
    int g;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    req0 = 1'b1; a0 = 16'd100;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %0b want 0", busy); end
    req0 = 1'b0;
    tick();
    rst = 1'b1;
    core_done = 1'b1; core_result = 16'd10;
    tick();
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL mid_ack: got %0b want 0", ack0); end
    n_cmp++; if (res0 !== 16'd0) begin n_err++; $display("FAIL mid_res0: got %0d want 0", res0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_stray_done: busy=%0b want 0", busy); end
    core_done = 1'b0;
    tick();
    req0 = 1'b1; a0 = 16'd49;
    serve(16'd7, g);
    n_cmp++; if (g !== 0) begin n_err++; $display("FAIL mid_next_gnt: got %0d want 0", g); end
    n_cmp++; if (res0 !== 16'd7) begin n_err++; $display("FAIL mid_next_res0: got %0d want 7", res0); end
  endtask

  initial begin
    test_reset();
    test_simul();
    test_back_to_back();
    test_basic();
    test_single_rr();
    test_drop();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_arb.md
SQRT_ARB -- requirements
Module: sqrt_arb

Interface
REQ-001 Parameter: TIMEOUT, default 64, max cycles to wait for core_done before abort (2..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 operation request, held high until ack0.
REQ-005 a0  input  16  requester 0 radicand, stable while req0 high.
REQ-006 ack0  output  1  requester 0 completion, res0/err valid while high.
REQ-007 res0  output  16  requester 0 result register.
REQ-008 req1 / a1 / ack1 / res1: same as REQ-004..007 for requester 1.
REQ-009 err  output  1  timeout flag for the transaction currently acknowledged.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 core_init  output  1  start pulse to the shared sqrt core.
REQ-012 core_a  output  16  registered radicand to the sqrt core.
REQ-013 core_result  input  16  sqrt core result, valid when core_done high.
REQ-014 core_done  input  1  sqrt core completion, level or pulse.

Function
REQ-015 FSM states: IDLE, START, WAIT, RESP; one transaction at a time.
REQ-016 IDLE: a grant occurs when either req is high; core_a <= granted operand, gnt <= index, next START.
REQ-017 Arbitration is round-robin: with both reqs high, the port not granted last wins; the last-grant pointer updates on every grant.
REQ-018 A single requester is granted regardless of the pointer.
REQ-019 START: core_init high for exactly one cycle, timeout counter cleared, next WAIT.
REQ-020 WAIT: the first cycle with core_done high captures core_result into res[gnt], clears err, next RESP.
REQ-021 WAIT: the counter increments each cycle; on reaching TIMEOUT without core_done, res[gnt] <= 16'hFFFF, err <= 1, next RESP.
REQ-022 core_done outside WAIT is ignored.
REQ-023 RESP: ack[gnt] is high, the other ack is low; ack stays high while req[gnt] is high (4-phase handshake).
REQ-024 RESP: req[gnt] low -> IDLE next cycle, and ack is high for at least one cycle even if req already dropped.
REQ-025 res0/res1 hold their last value until overwritten by a new transaction on that port.
REQ-026 Latency: req sampled in IDLE at cycle t -> core_init at t+1 -> WAIT from t+2 -> core_done at cycle d -> ack at d+1.
REQ-027 A req dropped during START/WAIT does not abort the transaction; the result is still written and ack is pulsed for one cycle.
REQ-028 ack0 and ack1 are never high simultaneously; core_init is never high outside START.

Reset
REQ-029 rst low asynchronously forces IDLE; ack0=ack1=0, core_init=0, busy=0, err=0, core_a=0, res0=res1=0, counter=0.
REQ-030 Reset last-grant pointer = 1, so req0 wins the first simultaneous request.
REQ-031 Reset asserted mid-transaction abandons the transaction with no ack; the first edge after release starts in IDLE.

Verification
REQ-032 req0=1, a0=144, core returns 12 after 17 cycles -> core_init one cycle at t+1; ack0 at done+1; res0=12, err=0.
REQ-033 req0 and req1 high at the same edge after reset, a0=65535, a1=4 -> port 0 served first (res0=255), then port 1 (res1=2); ack0 and ack1 never overlap.
REQ-034 Three back-to-back simultaneous request pairs -> grant order 0,1,0,1,0,1.
REQ-035 core_done held low, TIMEOUT=64 -> RESP entered 64 cycles into WAIT; res1=16'hFFFF, err=1 with ack1; the next normal transaction clears err.
REQ-036 rst low during WAIT, core_done arriving later -> no ack, busy=0 immediately, res unchanged (0); the next req completes normally.
REQ-037 req1 held high 5 cycles after ack1 -> ack1 stays high 5 cycles, no second core_init until req1 drops and IDLE is re-entered.
